// File: rtl/fact_sched.sv
// Round-robin job scheduler that shares one factorial accelerator between two requesters.
// Runs the write-n / Go / poll / read-result bus sequence and returns a tagged response.
module fact_sched #(
  parameter int POLL_DELAY     = 2,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_W          = 10
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        req0_valid,
  input  logic [3:0]  req0_n,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [3:0]  req1_n,
  output logic        req1_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        busy,
  output logic [1:0]  acc_A,
  output logic        acc_WE,
  output logic [3:0]  acc_WD,
  input  logic [31:0] acc_RD
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_N, S_WR_GO, S_WAIT, S_POLL, S_RD_RES, S_RESP
  } state_t;

  state_t           state, state_d;
  logic             ptr;
  logic [3:0]       n_q;
  logic             id_q;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      result_q;
  logic             err_q;
  logic             to_q;

  logic gnt_vld;
  logic gnt_id;
  logic poll_to;

  assign gnt_vld = req0_valid | req1_valid;
  // With both requesting, ptr names the side that was not served last.
  assign gnt_id  = (req0_valid & req1_valid) ? ptr : req1_valid;
  assign poll_to = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state    <= S_IDLE;
      ptr      <= 1'b0;
      n_q      <= '0;
      id_q     <= 1'b0;
      cnt      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state <= state_d;
      case (state)
        S_IDLE: begin
          if (gnt_vld) begin
            n_q  <= gnt_id ? req1_n : req0_n;
            id_q <= gnt_id;
            ptr  <= ~gnt_id;
          end
        end
        S_WR_GO: cnt <= CNT_W'(POLL_DELAY);
        S_WAIT:  cnt <= (cnt <= CNT_W'(1)) ? '0 : cnt - CNT_W'(1);
        S_POLL: begin
          if (acc_RD[1]) begin
            err_q    <= 1'b1;
            result_q <= '0;
          end else if (!acc_RD[0]) begin
            if (poll_to) begin
              to_q     <= 1'b1;
              result_q <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        S_RD_RES: result_q <= acc_RD;
        S_RESP: begin
          if (rsp_ready) begin
            err_q <= 1'b0;
            to_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d     = state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp_valid   = 1'b0;
    rsp_id      = id_q;
    rsp_result  = result_q;
    rsp_err     = err_q;
    rsp_timeout = to_q;
    busy        = (state != S_IDLE);
    acc_A       = 2'd0;
    acc_WE      = 1'b0;
    acc_WD      = 4'd0;
    case (state)
      S_IDLE: begin
        if (gnt_vld) begin
          req0_ready = ~gnt_id;
          req1_ready = gnt_id;
          state_d    = S_WR_N;
        end
      end
      S_WR_N: begin
        acc_A   = 2'd0;
        acc_WE  = 1'b1;
        acc_WD  = n_q;
        state_d = S_WR_GO;
      end
      S_WR_GO: begin
        acc_A   = 2'd1;
        acc_WE  = 1'b1;
        acc_WD  = 4'b0001;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt <= CNT_W'(1)) state_d = S_POLL;
      end
      S_POLL: begin
        acc_A = 2'd2;
        if (acc_RD[1])      state_d = S_RESP;
        else if (acc_RD[0]) state_d = S_RD_RES;
        else if (poll_to)   state_d = S_RESP;
      end
      S_RD_RES: begin
        acc_A   = 2'd3;
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // The reset cycle must not leak a half-finished bus access or response.
    if (!Rst) begin
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      rsp_valid   = 1'b0;
      rsp_id      = 1'b0;
      rsp_result  = '0;
      rsp_err     = 1'b0;
      rsp_timeout = 1'b0;
      busy        = 1'b0;
      acc_A       = 2'd0;
      acc_WE      = 1'b0;
      acc_WD      = 4'd0;
    end
  end

endmodule

// File: tb/tb_fact_sched.sv
// Randomised and directed bench for fact_sched against a behavioural accelerator and job-level scoreboard.
module tb_fact_sched;

  localparam int PD = 2;
  localparam int TO = 8;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0]  req0_n, req1_n;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, rsp_timeout, busy;
  logic [31:0] rsp_result;
  logic [1:0]  acc_A;
  logic        acc_WE;
  logic [3:0]  acc_WD;
  logic [31:0] acc_RD;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  fact_sched #(.POLL_DELAY(PD), .TIMEOUT_CYCLES(TO), .CNT_W(10)) dut (
    .Clk(Clk), .Rst(Rst),
    .req0_valid(req0_valid), .req0_n(req0_n), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_n(req1_n), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .busy(busy), .acc_A(acc_A), .acc_WE(acc_WE), .acc_WD(acc_WD), .acc_RD(acc_RD)
  );

  function automatic logic [31:0] fact_fn(input logic [3:0] n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 2; i <= int'(n); i++) r = r * 32'(i);
    return r;
  endfunction

  // Accelerator model: status sets mdl_dly+1 edges after Go; n>12 reports Err together with Done.
  int         mdl_dly   = 0;
  bit         mdl_never = 1'b0;
  logic [3:0] m_n       = '0;
  logic       m_done    = 1'b0;
  logic       m_err     = 1'b0;
  logic       m_run     = 1'b0;
  int         m_cnt     = 0;

  always @(posedge Clk) begin
    if (acc_WE && acc_A == 2'd0) m_n <= acc_WD;
    if (acc_WE && acc_A == 2'd1 && acc_WD[0]) begin
      m_done <= 1'b0;
      m_err  <= 1'b0;
      m_run  <= !mdl_never;
      m_cnt  <= mdl_dly;
    end else if (m_run) begin
      if (m_cnt == 0) begin
        m_run  <= 1'b0;
        m_done <= 1'b1;
        m_err  <= (m_n > 4'd12);
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  always_comb begin
    acc_RD = '0;
    case (acc_A)
      2'd0: acc_RD = {28'd0, m_n};
      2'd2: acc_RD = {30'd0, m_err, m_done};
      2'd3: acc_RD = fact_fn(m_n);
      default: acc_RD = '0;
    endcase
  end

  // Bus activity counters, sampled mid-cycle.
  int         we_n_cnt = 0, we_go_cnt = 0, poll_cnt = 0, rd3_cnt = 0, rdy_busy_cnt = 0, rsp_cyc_cnt = 0;
  logic [3:0] last_wd_n = '0, last_wd_go = '0;

  always @(negedge Clk) begin
    if (Rst === 1'b1) begin
      if (acc_WE && acc_A == 2'd0) begin we_n_cnt++;  last_wd_n  = acc_WD; end
      if (acc_WE && acc_A == 2'd1) begin we_go_cnt++; last_wd_go = acc_WD; end
      if (!acc_WE && acc_A == 2'd2) poll_cnt++;
      if (!acc_WE && acc_A == 2'd3) rd3_cnt++;
      if ((req0_ready || req1_ready) && busy) rdy_busy_cnt++;
      if (rsp_valid) rsp_cyc_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(output int id);
    bit ok;
    ok = 1'b0;
    id = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (req0_ready || req1_ready) begin
        id = req1_ready ? 1 : 0;
        ok = 1'b1;
        break;
      end
    end
    chk("grant_seen", 32'(ok), 32'd1);
    @(posedge Clk); #1;
  endtask

  task automatic wait_rsp(output int lat);
    bit ok;
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      lat++;
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    chk("rsp_seen", 32'(ok), 32'd1);
  endtask

  bit rr_ptr = 1'b0;

  // One job end to end; expected grant and response come from the scoreboard rules.
  task automatic do_job(input bit v0, input bit v1, input logic [3:0] n0, input logic [3:0] n1,
                        input int stall, output int lat);
    int          exp_id, got, k;
    logic [3:0]  n;
    bit          exp_to, exp_err;
    logic [31:0] exp_res;
    exp_id  = (v0 && v1) ? int'(rr_ptr) : (v1 ? 1 : 0);
    n       = (exp_id == 1) ? n1 : n0;
    k       = (mdl_dly + 1 - PD > 0) ? mdl_dly + 1 - PD : 0;
    exp_to  = mdl_never || (k >= TO);
    exp_err = !exp_to && (n > 4'd12);
    exp_res = (exp_to || exp_err) ? 32'd0 : fact_fn(n);
    @(posedge Clk); #1;
    req0_valid = v0; req0_n = n0;
    req1_valid = v1; req1_n = n1;
    wait_grant(got);
    chk("grant_id", 32'(got), 32'(exp_id));
    rr_ptr = (exp_id == 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(lat);
    chk("rsp_id", 32'(rsp_id), 32'(exp_id));
    chk("rsp_result", rsp_result, exp_res);
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
    for (int s = 0; s < stall; s++) begin
      @(posedge Clk); #1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      @(negedge Clk);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_result", rsp_result, exp_res);
      chk("stall_id", 32'(rsp_id), 32'(exp_id));
      chk("stall_ready", 32'({req0_ready, req1_ready}), 32'd0);
    end
    @(posedge Clk); #1;
    rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge Clk); #1;
    rsp_ready = 1'b0;
    @(negedge Clk);
    chk("idle_after_rsp", 32'({busy, rsp_valid}), 32'd0);
  endtask

  initial begin
    int lat, got, s_n, s_go, s_rd, s_poll, s_rsp;
    bit found;
    Rst = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_n = '0; req1_n = '0;

    @(posedge Clk); #1;
    req0_valid = 1'b1;
    @(negedge Clk);
    chk("reset_outputs", 32'({busy, rsp_valid, acc_WE, acc_A, req0_ready, req1_ready}), 32'd0);
    @(posedge Clk); #1;
    req0_valid = 1'b0; Rst = 1'b1;
    @(negedge Clk);
    chk("after_reset_busy", 32'(busy), 32'd0);

    // Single job with immediate Done.
    mdl_dly = 0;
    s_n = we_n_cnt; s_go = we_go_cnt; s_rd = rd3_cnt;
    do_job(1'b1, 1'b0, 4'd5, 4'd0, 0, lat);
    chk("latency", 32'(lat), 32'(5 + PD));
    chk("we_n_pulses", 32'(we_n_cnt - s_n), 32'd1);
    chk("we_n_data", 32'(last_wd_n), 32'd5);
    chk("we_go_pulses", 32'(we_go_cnt - s_go), 32'd1);
    chk("we_go_data", 32'(last_wd_go), 32'd1);
    chk("rd_res_reads", 32'(rd3_cnt - s_rd), 32'd1);

    // Contention: both held valid, grants must alternate.
    @(posedge Clk); #1;
    req0_valid = 1'b1; req0_n = 4'd3;
    req1_valid = 1'b1; req1_n = 4'd4;
    rsp_ready  = 1'b1;
    for (int j = 0; j < 4; j++) begin
      wait_grant(got);
      chk("cont_grant", 32'(got), 32'(rr_ptr));
      rr_ptr = (got == 0);
      wait_rsp(lat);
      chk("cont_result", rsp_result, (got == 0) ? 32'd6 : 32'd24);
    end
    @(posedge Clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    @(posedge Clk); #1;

    // Error: Err wins over Done and the result read is skipped.
    s_rd = rd3_cnt;
    do_job(1'b0, 1'b1, 4'd0, 4'd13, 0, lat);
    chk("err_no_rd_res", 32'(rd3_cnt - s_rd), 32'd0);

    // Timeout, then a normal job.
    mdl_never = 1'b1;
    s_poll = poll_cnt; s_rd = rd3_cnt;
    do_job(1'b1, 1'b0, 4'd7, 4'd0, 0, lat);
    chk("timeout_polls", 32'(poll_cnt - s_poll), 32'(TO));
    chk("timeout_no_rd_res", 32'(rd3_cnt - s_rd), 32'd0);
    mdl_never = 1'b0;
    do_job(1'b0, 1'b1, 4'd0, 4'd6, 0, lat);

    // Backpressure: rsp_ready low for 10 rsp_valid cycles.
    do_job(1'b1, 1'b0, 4'd6, 4'd0, 9, lat);

    // Reset during POLL: job dropped, pointer back to req0.
    mdl_never = 1'b1;
    do_job(1'b1, 1'b0, 4'd2, 4'd0, 0, lat);
    @(posedge Clk); #1;
    req0_valid = 1'b1; req0_n = 4'd3;
    wait_grant(got);
    req0_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (acc_A == 2'd2) begin found = 1'b1; break; end
    end
    chk("reached_poll", 32'(found), 32'd1);
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(negedge Clk);
    chk("rst_cycle_outputs", 32'({acc_WE, acc_A, busy, rsp_valid}), 32'd0);
    @(posedge Clk); #1;
    Rst = 1'b1;
    rr_ptr = 1'b0;
    @(negedge Clk);
    chk("post_rst_outputs", 32'({acc_WE, acc_A, busy, rsp_valid, rsp_result}), 32'd0);
    s_rsp = rsp_cyc_cnt;
    repeat (20) @(negedge Clk);
    chk("no_rsp_after_rst", 32'(rsp_cyc_cnt - s_rsp), 32'd0);
    mdl_never = 1'b0;
    do_job(1'b1, 1'b1, 4'd2, 4'd9, 0, lat);

    // Randomised jobs.
    for (int j = 0; j < 30; j++) begin
      int r;
      r = $urandom_range(1, 3);
      mdl_dly = $urandom_range(0, 11);
      do_job(r[0], r[1], 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             $urandom_range(0, 2), lat);
    end

    chk("ready_while_busy", 32'(rdy_busy_cnt), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
